// File: rtl/instr_encoder.sv
// Field-bundle to RV32I word assembler. It streams one program of PROG_LEN words,
// each tagged with its write address, into a PE instruction memory.
module instr_encoder #(
  parameter int          ADDR_W   = 8,
  parameter int          PROG_LEN = 16,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        op,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [4:0]        rd,
  input  logic [11:0]       imm12,
  input  logic [19:0]       immhi,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_illegal,
  output logic              busy,
  output logic              done,
  output logic [7:0]        illegal_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [ADDR_W:0] LEN  = (ADDR_W+1)'(PROG_LEN);
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(PROG_LEN - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W:0]   acc_cnt_q, acc_cnt_d;
  logic [ADDR_W:0]   emit_cnt_q, emit_cnt_d;
  logic [7:0]        ill_cnt_q, ill_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              out_illegal_q, out_illegal_d;

  logic [31:0] enc_word;
  logic        enc_illegal;
  logic        in_hs;
  logic        out_hs;

  always_comb begin
    enc_word    = NOP_WORD;
    enc_illegal = 1'b0;
    case (op)
      7'd51:               enc_word = {funct7, rs2, rs1, funct3, rd, op};
      7'd3, 7'd19, 7'd103: enc_word = {imm12, rs1, funct3, rd, op};
      7'd35:               enc_word = {imm12[11:5], rs2, rs1, funct3, imm12[4:0], op};
      7'd99:               enc_word = {imm12[11], imm12[9:4], rs2, rs1, funct3,
                                       imm12[3:0], imm12[10], op};
      7'd23, 7'd55:        enc_word = {immhi, rd, op};
      7'd111:              enc_word = {immhi[19], immhi[9:0], immhi[10], immhi[18:11], rd, op};
      default: begin
        enc_word    = NOP_WORD;
        enc_illegal = 1'b1;
      end
    endcase
  end

  // Accept only when the output slot is free or draining this cycle, and the session still has room.
  assign in_ready = (state_q == S_LOAD) && (!out_valid_q || out_ready) && (acc_cnt_q < LEN);
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid_q && out_ready;

  always_comb begin
    state_d       = state_q;
    acc_cnt_d     = acc_cnt_q;
    emit_cnt_d    = emit_cnt_q;
    ill_cnt_d     = ill_cnt_q;
    out_valid_d   = out_valid_q;
    out_instr_d   = out_instr_q;
    out_addr_d    = out_addr_q;
    out_illegal_d = out_illegal_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_LOAD;
          acc_cnt_d  = '0;
          emit_cnt_d = '0;
          ill_cnt_d  = '0;
        end
      end
      S_LOAD: begin
        if (in_hs) begin
          acc_cnt_d = acc_cnt_q + 1'b1;
          if (enc_illegal && (ill_cnt_q != 8'hFF)) begin
            ill_cnt_d = ill_cnt_q + 8'd1;
          end
        end
        if (out_hs) begin
          emit_cnt_d = emit_cnt_q + 1'b1;
          if (emit_cnt_q == LAST) begin
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new word overwrites the slot directly, so a simultaneous drain leaves no bubble.
    if (in_hs) begin
      out_valid_d   = 1'b1;
      out_instr_d   = enc_word;
      out_addr_d    = acc_cnt_q[ADDR_W-1:0];
      out_illegal_d = enc_illegal;
    end else if (out_hs) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      acc_cnt_q     <= '0;
      emit_cnt_q    <= '0;
      ill_cnt_q     <= '0;
      out_valid_q   <= 1'b0;
      out_instr_q   <= '0;
      out_addr_q    <= '0;
      out_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_cnt_q     <= acc_cnt_d;
      emit_cnt_q    <= emit_cnt_d;
      ill_cnt_q     <= ill_cnt_d;
      out_valid_q   <= out_valid_d;
      out_instr_q   <= out_instr_d;
      out_addr_q    <= out_addr_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_instr   = out_instr_q;
  assign out_addr    = out_addr_q;
  assign out_illegal = out_illegal_q;
  assign busy        = (state_q == S_LOAD);
  assign done        = (state_q == S_DONE);
  assign illegal_cnt = ill_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized scoreboard bench for instr_encoder. Expected words come from RISC-V
// format rules applied to branch/jump byte offsets; a negedge monitor checks outputs.
module tb_instr_encoder;

  localparam int ADDR_W   = 8;
  localparam int PROG_LEN = 256;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [6:0]        op = '0;
  logic [2:0]        funct3 = '0;
  logic [6:0]        funct7 = '0;
  logic [4:0]        rs1 = '0;
  logic [4:0]        rs2 = '0;
  logic [4:0]        rd = '0;
  logic [11:0]       imm12 = '0;
  logic [19:0]       immhi = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              out_illegal;
  logic              busy;
  logic              done;
  logic [7:0]        illegal_cnt;

  instr_encoder #(.ADDR_W(ADDR_W), .PROG_LEN(PROG_LEN), .NOP_WORD(32'h0000_0013)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .funct3(funct3), .funct7(funct7), .rs1(rs1), .rs2(rs2), .rd(rd),
    .imm12(imm12), .immhi(immhi), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .out_illegal(out_illegal),
    .busy(busy), .done(done), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // Reference model: opcode legality and the word each format produces
  function automatic logic is_legal(input logic [6:0] o);
    case (o)
      7'd51, 7'd3, 7'd19, 7'd103, 7'd35, 7'd99, 7'd23, 7'd55, 7'd111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_enc(input logic [6:0] o, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [4:0] r1,
                                          input logic [4:0] r2, input logic [4:0] rdv,
                                          input logic [11:0] i12, input logic [19:0] ihi);
    logic [12:0] boff;
    logic [20:0] joff;
    boff = {i12, 1'b0};
    joff = {ihi, 1'b0};
    case (o)
      7'd51:               return {f7, r2, r1, f3, rdv, o};
      7'd3, 7'd19, 7'd103: return {i12, r1, f3, rdv, o};
      7'd35:               return {i12[11:5], r2, r1, f3, i12[4:0], o};
      7'd99:               return {boff[12], boff[10:5], r2, r1, f3, boff[4:1], boff[11], o};
      7'd23, 7'd55:        return {ihi, rdv, o};
      7'd111:              return {joff[20], joff[10:1], joff[11], joff[19:12], rdv, o};
      default:             return 32'h0000_0013;
    endcase
  endfunction

  typedef struct {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] addr;
    logic              ill;
  } exp_t;

  typedef enum {M_IDLE, M_LOAD, M_DONE} mstate_t;

  exp_t              sb_q[$];
  mstate_t           m_state = M_IDLE;
  int                m_acc = 0;
  int                m_emit = 0;
  int                m_ill = 0;
  logic              hold = 1'b0;
  logic [31:0]       h_instr;
  logic [ADDR_W-1:0] h_addr;
  logic              h_ill;

  // Monitor / scoreboard
  always @(negedge clk) begin
    mstate_t st;
    exp_t    e;
    logic    exp_rdy;
    if (rst) begin
      sb_q.delete();
      m_state = M_IDLE;
      m_acc   = 0;
      m_emit  = 0;
      m_ill   = 0;
      hold    = 1'b0;
    end else begin
      st = m_state;
      if (hold) begin
        check("stall_instr", out_instr, h_instr);
        check("stall_addr", 32'(out_addr), 32'(h_addr));
        check("stall_illegal", 32'(out_illegal), 32'(h_ill));
        hold = 1'b0;
      end
      check("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
      if (st == M_LOAD) begin
        check("busy", 32'(busy), 32'd1);
        check("done_in_load", 32'(done), 32'd0);
        check("illegal_cnt", 32'(illegal_cnt), 32'(m_ill));
        exp_rdy = ((sb_q.size() == 0) || out_ready) && (m_acc < PROG_LEN);
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (out_valid && out_ready && (sb_q.size() != 0)) begin
          e = sb_q.pop_front();
          check("word_instr", out_instr, e.instr);
          check("word_addr", 32'(out_addr), 32'(e.addr));
          check("word_illegal", 32'(out_illegal), 32'(e.ill));
          m_emit++;
          if (m_emit == PROG_LEN) m_state = M_DONE;
        end else if (out_valid) begin
          hold    = 1'b1;
          h_instr = out_instr;
          h_addr  = out_addr;
          h_ill   = out_illegal;
        end
        if (in_valid && in_ready) begin
          e.instr = ref_enc(op, funct3, funct7, rs1, rs2, rd, imm12, immhi);
          e.addr  = m_acc[ADDR_W-1:0];
          e.ill   = !is_legal(op);
          sb_q.push_back(e);
          m_acc++;
          if (e.ill && m_ill < 255) m_ill++;
        end
      end else begin
        check("busy_idle", 32'(busy), 32'd0);
        check("done_flag", 32'(done), 32'(st == M_DONE));
        check("in_ready_idle", 32'(in_ready), 32'd0);
        if (start) begin
          m_state = M_LOAD;
          m_acc   = 0;
          m_emit  = 0;
          m_ill   = 0;
        end
      end
    end
  end

  logic rand_rdy  = 1'b0;
  logic fixed_rdy = 1'b1;

  always @(posedge clk) begin
    #2;
    out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : fixed_rdy;
  end

  logic [6:0] legal_ops [9] = '{7'd51, 7'd3, 7'd19, 7'd103, 7'd35, 7'd99, 7'd23, 7'd55, 7'd111};

  // All stimulus tasks start and end at posedge+1
  task automatic send(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdv,
                      input logic [11:0] i12, input logic [19:0] ihi);
    int t;
    op = o; funct3 = f3; funct7 = f7; rs1 = r1; rs2 = r2; rd = rdv; imm12 = i12; immhi = ihi;
    in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 500) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) fail_now("send_timeout");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand(input logic force_illegal);
    logic [6:0] o;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
    if (force_illegal) begin
      o = 7'($urandom);
      while (is_legal(o)) o = 7'($urandom);
    end else if ($urandom_range(0, 4) == 0) begin
      o = 7'($urandom);
    end else begin
      o = legal_ops[$urandom_range(0, 8)];
    end
    send(o, 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
         12'($urandom), 20'($urandom));
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("start_busy", 32'(busy), 32'd1);
    check("start_illegal_cnt", 32'(illegal_cnt), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    @(negedge clk);
    while (!done && t < 3000) begin
      t++;
      @(negedge clk);
    end
    if (!done) fail_now("wait_done");
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_out_illegal", 32'(out_illegal), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_illegal_cnt", 32'(illegal_cnt), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;

    // Session 1: directed words, then random fill
    do_start();
    send(7'd51, 3'd4, 7'd0, 5'd3, 5'd2, 5'd1, 12'd0, 20'd0);
    @(negedge clk);
    check("xor_valid", 32'(out_valid), 32'd1);
    check("xor_instr", out_instr, 32'h0021_C0B3);
    check("xor_addr", 32'(out_addr), 32'd0);
    check("xor_illegal", 32'(out_illegal), 32'd0);
    @(posedge clk);
    #1;

    send(7'd35, 3'd0, 7'd0, 5'd23, 5'd11, 5'd0, 12'h023, 20'd0);
    op = 7'd55; rd = 5'd1; immhi = 20'h00081; in_valid = 1'b1;
    @(negedge clk);
    check("sb_instr", out_instr, 32'h02BB_81A3);
    check("sb_addr", 32'(out_addr), 32'd1);
    check("lui_accepted_b2b", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("lui_valid_no_bubble", 32'(out_valid), 32'd1);
    check("lui_instr", out_instr, 32'h0008_10B7);
    check("lui_addr", 32'(out_addr), 32'd2);
    @(posedge clk);
    #1;

    send(7'h7F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 12'd0, 20'd0);
    @(negedge clk);
    check("ill_instr", out_instr, 32'h0000_0013);
    check("ill_flag", 32'(out_illegal), 32'd1);
    check("ill_cnt", 32'(illegal_cnt), 32'd1);
    @(posedge clk);
    #1;
    send(7'd19, 3'd0, 7'd0, 5'd5, 5'd0, 5'd6, 12'h7FF, 20'd0);
    @(negedge clk);
    check("after_ill_addr", 32'(out_addr), 32'd4);
    @(posedge clk);
    #1;

    // Backpressure: word 5 stalls in the output slot while word 6 waits
    fixed_rdy = 1'b0;
    send(7'd99, 3'd1, 7'd0, 5'd7, 5'd8, 5'd0, 12'hA5C, 20'd0);
    op = 7'd111; rd = 5'd9; immhi = 20'h9_3C5A; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_addr", 32'(out_addr), 32'd5);
      @(posedge clk);
      #1;
    end
    fixed_rdy = 1'b1;
    send(7'd111, 3'd0, 7'd0, 5'd0, 5'd0, 5'd9, 12'd0, 20'h9_3C5A);

    rand_rdy = 1'b1;
    while (m_acc < PROG_LEN) send_rand(1'b0);
    wait_done();
    in_valid = 1'b1;
    @(negedge clk);
    check("done_hold", 32'(done), 32'd1);
    check("done_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;

    // Session 2: every word illegal, counter must stop at 255
    do_start();
    while (m_acc < PROG_LEN) send_rand(1'b1);
    wait_done();
    @(negedge clk);
    check("sat_illegal_cnt", 32'(illegal_cnt), 32'd255);
    @(posedge clk);
    #1;

    // Session 3: reset while a word is pending
    do_start();
    repeat (10) send_rand(1'b0);
    rand_rdy  = 1'b0;
    fixed_rdy = 1'b1;
    send_rand(1'b0);
    fixed_rdy = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_instr", out_instr, 32'd0);
    check("mid_rst_addr", 32'(out_addr), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_illegal_cnt", 32'(illegal_cnt), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
